// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one MMU port between the CPU (port 0)
// and a secondary bus master (port 1); registers the winning request and returns read data.
module mem_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          wren0,
  output logic [DW-1:0] rdata0,
  output logic          ack0,
  output logic          stall0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          wren1,
  output logic [DW-1:0] rdata1,
  output logic          ack1,
  output logic          stall1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  input  logic          mem_stall,
  output logic          busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

  state_t     state;
  logic [3:0] lat_cnt;
  logic       owner;
  logic       last_grant;
  logic       win1;

  // Port 1 wins when alone, or on a tie when port 0 was granted last.
  always_comb begin
    win1 = req1 & (~req0 | ~last_grant);
  end

  assign stall0 = req0 & ~ack0;
  assign stall1 = req1 & ~ack1;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      lat_cnt    <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          // The ack cycle is the mandatory bubble: the acked requester may
          // still be showing its old request, so nothing is granted then.
          if ((req0 | req1) && !(ack0 | ack1)) begin
            owner      <= win1;
            last_grant <= win1;
            mem_addr   <= win1 ? addr1  : addr0;
            mem_data   <= win1 ? wdata1 : wdata0;
            mem_wren   <= win1 ? wren1  : wren0;
            lat_cnt    <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_stall) begin
            if (mem_wren) begin
              mem_wren <= 1'b0;
              ack0     <= ~owner;
              ack1     <= owner;
              state    <= IDLE;
            end else if (lat_cnt == LAT_LAST) begin
              if (owner) rdata1 <= mem_q;
              else       rdata0 <= mem_q;
              ack0  <= ~owner;
              ack1  <= owner;
              state <= IDLE;
            end else begin
              lat_cnt <= lat_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level countdown model checked every cycle,
// plus directed scenarios with hand-computed cycle/value expectations.
module tb_mem_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          nRst;
  logic          req   [2];
  logic          wren  [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata [2];
  logic          ack   [2];
  logic          stall [2];
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;
  logic          mem_stall;
  logic          busy;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .nRst(nRst),
    .req0(req[0]), .addr0(addr[0]), .wdata0(wdata[0]), .wren0(wren[0]),
    .rdata0(rdata[0]), .ack0(ack[0]), .stall0(stall[0]),
    .req1(req[1]), .addr1(addr[1]), .wdata1(wdata[1]), .wren1(wren[1]),
    .rdata1(rdata[1]), .ack1(ack[1]), .stall1(stall[1]),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .mem_stall(mem_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int t           = 0;

  // Transaction-level model: a granted transaction needs a number of
  // unstalled clock edges (1 for a write, RD_LAT for a read) before its ack.
  int            m_busy, m_owner, m_left, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_wren;
  logic          m_ack   [2];
  logic [DW-1:0] m_rdata [2];

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_left = 0; m_last = 1;
    m_addr = '0; m_data = '0; m_wren = 1'b0;
    m_ack[0] = 1'b0; m_ack[1] = 1'b0;
    m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  task automatic model_step();
    logic had_ack;
    int   w;
    if (!nRst) begin
      model_reset();
      return;
    end
    had_ack  = m_ack[0] | m_ack[1];
    m_ack[0] = 1'b0;
    m_ack[1] = 1'b0;
    if (m_busy == 0) begin
      if (!had_ack && (req[0] || req[1])) begin
        if (req[0] && req[1]) w = 1 - m_last;
        else                  w = req[1] ? 1 : 0;
        m_busy = 1; m_owner = w; m_last = w;
        m_addr = addr[w]; m_data = wdata[w]; m_wren = wren[w];
        m_left = wren[w] ? 1 : RD_LAT;
      end
    end else if (!mem_stall) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_ack[m_owner] = 1'b1;
        if (!m_wren) m_rdata[m_owner] = mem_q;
        m_wren = 1'b0;
        m_busy = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  task automatic check_cycle();
    check("ack0",     64'(ack[0]),   64'(m_ack[0]));
    check("ack1",     64'(ack[1]),   64'(m_ack[1]));
    check("rdata0",   64'(rdata[0]), 64'(m_rdata[0]));
    check("rdata1",   64'(rdata[1]), 64'(m_rdata[1]));
    check("mem_addr", 64'(mem_addr), 64'(m_addr));
    check("mem_data", 64'(mem_data), 64'(m_data));
    check("mem_wren", 64'(mem_wren), 64'(m_wren));
    check("busy",     64'(busy),     64'(m_busy != 0));
    check("stall0",   64'(stall[0]), 64'(req[0] & ~m_ack[0]));
    check("stall1",   64'(stall[1]), 64'(req[1] & ~m_ack[1]));
  endtask

  // Advance one clock: inputs already driven are what the coming edge samples.
  task automatic tick();
    model_step();
    @(negedge clk);
    t++;
    check_cycle();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wren[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    mem_stall = 1'b0;
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    idle_inputs();
    model_reset();
    tick();
    tick();
    nRst = 1'b1;
    t = 0;
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = r; wren[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  int ack_t[$];
  int ack_p[$];

  initial begin
    nRst = 1'b1;
    mem_q = '0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();
    check("reset busy",   64'(busy),     64'd0);
    check("reset wren",   64'(mem_wren), 64'd0);
    check("reset addr",   64'(mem_addr), 64'd0);
    check("reset rdata0", 64'(rdata[0]), 64'd0);

    // Plain read on port 0.
    mem_q = 32'hDEADBEEF;
    drive(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    #1 check("rd stall0 t0", 64'(stall[0]), 64'd1);
    tick();
    check("rd mem_addr t1", 64'(mem_addr), 64'h0010);
    check("rd stall0 t1",   64'(stall[0]), 64'd1);
    tick();
    check("rd stall0 t2",   64'(stall[0]), 64'd1);
    check("rd ack0 t2",     64'(ack[0]),   64'd0);
    tick();
    check("rd ack0 t3",     64'(ack[0]),   64'd1);
    check("rd rdata0 t3",   64'(rdata[0]), 64'hDEADBEEF);
    check("rd stall0 t3",   64'(stall[0]), 64'd0);
    check("rd rdata1 t3",   64'(rdata[1]), 64'd0);
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    check("rd ack0 t4",     64'(ack[0]),   64'd0);

    // Write on port 1.
    t = 0;
    drive(1, 1'b1, 1'b1, 16'h0100, 32'h12345678);
    tick();
    check("wr mem_wren t1", 64'(mem_wren), 64'd1);
    check("wr mem_addr t1", 64'(mem_addr), 64'h0100);
    check("wr mem_data t1", 64'(mem_data), 64'h12345678);
    tick();
    check("wr ack1 t2",     64'(ack[1]),   64'd1);
    check("wr mem_wren t2", 64'(mem_wren), 64'd0);
    check("wr ack0 t2",     64'(ack[0]),   64'd0);
    check("wr rdata0 t2",   64'(rdata[0]), 64'hDEADBEEF);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // Both ports reading, requests held: strict alternation starting at port 0.
    do_reset();
    drive(0, 1'b1, 1'b0, 16'h0020, 32'h0);
    drive(1, 1'b1, 1'b0, 16'h0030, 32'h0);
    ack_t.delete(); ack_p.delete();
    for (int k = 0; k < 16; k++) begin
      mem_q = $urandom;
      tick();
      if (ack[0]) begin ack_t.push_back(t); ack_p.push_back(0); end
      if (ack[1]) begin ack_t.push_back(t); ack_p.push_back(1); end
    end
    check("rr ack count", 64'(ack_t.size()), 64'd4);
    for (int k = 0; k < 4 && k < ack_t.size(); k++) begin
      check("rr ack time", 64'(ack_t[k]), 64'(3 + 4 * k));
      check("rr ack port", 64'(ack_p[k]), 64'(k % 2));
    end
    idle_inputs();
    tick();
    tick();

    // Read with three stall cycles inside ACCESS.
    t = 0;
    drive(0, 1'b1, 1'b0, 16'h0044, 32'h0);
    for (int k = 0; k < 7; k++) begin
      mem_q = 32'hA000_0000 + 32'(t);
      mem_stall = (t >= 1 && t <= 3);
      tick();
      if (t >= 1 && t <= 5) check("stall mem_addr", 64'(mem_addr), 64'h0044);
      if (t == 5) check("stall ack0 t5", 64'(ack[0]), 64'd0);
      if (t == 6) begin
        check("stall ack0 t6",   64'(ack[0]),   64'd1);
        check("stall rdata0 t6", 64'(rdata[0]), 64'hA000_0005);
      end
    end
    idle_inputs();
    tick();

    // Reset pulled during a write in ACCESS.
    t = 0;
    drive(0, 1'b1, 1'b1, 16'h0200, 32'hCAFEF00D);
    tick();
    check("abort wren before", 64'(mem_wren), 64'd1);
    #2 nRst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("abort wren async", 64'(mem_wren), 64'd0);
    check("abort busy async", 64'(busy),     64'd0);
    @(negedge clk);
    check_cycle();
    tick();
    nRst = 1'b1;
    tick();
    tick();
    check("abort no ack0", 64'(ack[0]), 64'd0);
    check("abort busy",    64'(busy),   64'd0);
    t = 0;
    drive(0, 1'b1, 1'b0, 16'h0300, 32'h0);
    drive(1, 1'b1, 1'b0, 16'h0310, 32'h0);
    tick();
    check("abort grant addr", 64'(mem_addr), 64'h0300);
    idle_inputs();
    for (int k = 0; k < 3; k++) tick();

    // Port 1 drops its read request right after grant.
    t = 0;
    drive(1, 1'b1, 1'b0, 16'h0400, 32'h0);
    mem_q = 32'h5555AAAA;
    tick();
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    tick();
    check("drop ack1 t3",   64'(ack[1]),   64'd1);
    check("drop rdata1 t3", 64'(rdata[1]), 64'h5555AAAA);
    drive(0, 1'b1, 1'b0, 16'h0500, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    check("drop ack0 t7",     64'(ack[0]),   64'd1);
    check("drop mem_addr t7", 64'(mem_addr), 64'h0500);
    idle_inputs();
    tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        req[i]   = ($urandom_range(0, 3) != 0);
        wren[i]  = $urandom_range(0, 1) != 0;
        addr[i]  = AW'($urandom);
        wdata[i] = $urandom;
      end
      mem_stall = ($urandom_range(0, 3) == 0);
      mem_q     = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single MMU port (address/data/q/wren/stall) between the CPU (port 0) and a secondary bus master such as a loader or DMA engine (port 1).
- Registers the winning request, drives the MMU, honours MMU stall, counts read latency, and returns read data with a one-cycle ack.
- Sits between CPU/secondary master and MMU in the top level, on the MMU clock domain.

Parameters:
- AW, 16, address width.
- DW, 32, data width.
- RD_LAT, 2, MMU read latency in unstalled cycles from address valid to q valid; legal 1..15.

Ports:
- clk  in  1  clock.
- nRst  in  1  reset; asynchronous, active-low.
- req0  in  1  port 0 request (CPU).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- wren0  in  1  port 0 write enable (1 = write, 0 = read).
- rdata0  out  DW  port 0 read data, valid while ack0.
- ack0  out  1  port 0 transaction complete, 1-cycle pulse.
- stall0  out  1  port 0 stall = req0 & ~ack0.
- req1, addr1, wdata1, wren1, rdata1, ack1, stall1: same as port 0, for port 1.
- mem_addr  out  AW  to MMU address.
- mem_data  out  DW  to MMU write data.
- mem_wren  out  1  to MMU write enable.
- mem_q  in  DW  from MMU read data.
- mem_stall  in  1  MMU stall; freezes the current transaction.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (nRst low, async): state = IDLE; mem_addr = 0; mem_data = 0; mem_wren = 0; ack0 = ack1 = 0; rdata0 = rdata1 = 0; lat_cnt = 0; last_grant = 1, so port 0 wins the first tie. Reset asserted mid-transaction aborts it immediately: mem_wren drops asynchronously and no ack is issued.
- States:
  - IDLE: when req0 or req1 is sampled high, select a winner, latch its addr, wdata and wren into mem_* and owner, set lat_cnt = 0, and go to ACCESS.
    - Only one request: it wins.
    - Both requests: the port not equal to last_grant wins (round-robin).
    - Set last_grant = winner.
  - ACCESS: mem_* held stable.
    - If mem_stall = 1: hold everything, lat_cnt frozen.
    - Write (mem_wren = 1), not stalled: pulse ack[owner] next cycle, clear mem_wren, go to IDLE.
    - Read, not stalled: increment lat_cnt. When lat_cnt = RD_LAT-1, capture mem_q into rdata[owner], pulse ack[owner], go to IDLE.
- Latency with no stall:
  - Write: ack 2 cycles after req sampled.
  - Read: ack 1+RD_LAT cycles after req sampled.
  - Each stall cycle adds exactly one cycle.
  - One IDLE bubble is required between transactions.
- ack is a single-cycle pulse. rdata[owner] holds its value until that port's next read ack. The non-owner's rdata is unchanged.
- Requesters hold req, addr, wdata and wren stable until ack. If req drops mid-transaction, the transaction still completes and the ack still pulses.
- A request arriving while in ACCESS waits. It is evaluated in the next IDLE, so no requester is starved: with both requests continuously asserted, grants strictly alternate.
- The same port may win consecutively only if the other port is not requesting.
- stallN is combinational: reqN & ~ackN. The CPU freezes on stall0.
- mem_wren is high only in ACCESS for a write and is never high in IDLE.

Test Plan:
- Reset, then req0 read addr 0x0010, RD_LAT = 2, mem_q = 0xDEADBEEF, no stall -> mem_addr = 0x0010 in the cycle after req; ack0 pulses 3 cycles after req with rdata0 = 0xDEADBEEF; stall0 high for exactly 3 cycles; rdata1 stays 0.
- req1 write addr 0x0100, data 0x12345678 -> mem_wren = 1 for exactly 1 cycle with mem_addr = 0x0100 and mem_data = 0x12345678; ack1 2 cycles after req; port 0 untouched.
- req0 and req1 asserted on the same cycle after reset, both reads, held high -> grant order 0,1,0,1; each ack separated by 4 cycles; no ack0 and ack1 in the same cycle.
- Read with mem_stall high for 3 cycles inside ACCESS -> mem_addr stable throughout; ack0 at 3+3 = 6 cycles after req; rdata0 equals the mem_q present on the cycle lat_cnt reaches RD_LAT-1 unstalled.
- nRst pulled low during a write in ACCESS -> mem_wren 0 in the same cycle (async); after release busy = 0, no ack, and the next simultaneous request is granted to port 0.
- req1 dropped one cycle after grant of a read -> transaction completes; ack1 still pulses at 1+RD_LAT and rdata1 updates; a following req0 is granted normally.
